// File: rtl/wb_dma_reader_pkg.sv
// wb_dma_reader_pkg: Wishbone widths and constants shared by the DMA reader files.
package wb_dma_reader_pkg;
  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam logic [3:0] SEL_ALL = 4'hF;
  typedef logic [ADR_W-1:0] wb_adr_t;
  typedef logic [DAT_W-1:0] wb_dat_t;
endpackage

// File: rtl/wb_dma_reader_fifo.sv
// wb_dma_fifo: synchronous first-word-fall-through FIFO, DEPTH a power of two.
module wb_dma_fifo
  import wb_dma_reader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DAT_W-1:0]         din,
  output logic [DAT_W-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DAT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_level;
  logic             w_pop;
  logic             w_push;
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= din;
  assign dout  = r_mem[r_rd];
  assign empty = (r_level == '0);
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign level = r_level;
endmodule

// File: rtl/wb_dma_reader.sv
// wb_dma_reader: Wishbone master reading a block of words, one classic read per cyc,
// into a FWFT FIFO exposed as a valid/ready stream.
module wb_dma_reader
  import wb_dma_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [15:0]      count,
  output logic             busy,
  output logic             done,
  output logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] dat_w,
  input  logic [DAT_W-1:0] dat_r,
  output logic [3:0]       sel,
  output logic             we,
  output logic             cyc,
  output logic             stb,
  input  logic             ack,
  output logic [DAT_W-1:0] src_data,
  output logic             src_valid,
  input  logic             src_ready
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  logic [2:0]       r_state;
  logic [ADR_W-1:0] r_adr;
  logic [15:0]      r_rem;
  logic             r_cyc;
  logic             r_busy;
  logic             r_done;
  logic             w_take;
  logic             w_room;
  logic             w_empty;
  logic             w_full;
  logic [LW-1:0]    w_level;
  assign w_take = (r_state == S_WAIT) & r_cyc & ack;
  assign w_room = w_level < LW'(FIFO_DEPTH);
  wb_dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .push  (w_take & ~w_full),
    .pop   (src_ready),
    .din   (dat_r),
    .dout  (src_data),
    .empty (w_empty),
    .full  (w_full),
    .level (w_level)
  );
  // GAP performs the room check itself so cyc is low for exactly one cycle between reads
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_rem   <= '0;
      r_cyc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (count != '0) begin
            r_adr   <= base_adr;
            r_rem   <= count;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end else r_done <= 1'b1;
        end
        S_REQ: if (w_room) begin
          r_cyc   <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_take) begin
          r_cyc   <= 1'b0;
          r_adr   <= r_adr + 1'b1;
          r_rem   <= r_rem - 1'b1;
          r_state <= S_GAP;
        end
        S_GAP: if (r_rem == '0) r_state <= S_DRAIN;
          else if (w_room) begin
            r_cyc   <= 1'b1;
            r_state <= S_WAIT;
          end else r_state <= S_REQ;
        S_DRAIN: if (w_empty) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy      = r_busy;
  assign done      = r_done;
  assign adr       = r_adr;
  assign cyc       = r_cyc;
  assign stb       = r_cyc;
  assign dat_w     = '0;
  assign sel       = SEL_ALL;
  assign we        = 1'b0;
  assign src_valid = ~w_empty;
endmodule
